// File: rtl/multi_clkgen.sv
// multi_clkgen: multi-channel programmable clock/strobe generator with lock indication and reconfiguration port
module multi_clkgen #(
  parameter int NUM_CLOCKS    = 4,
  parameter int CNT_W         = 16,
  parameter int LOCK_CYCLES   = 16,
  parameter int DEFAULT_DIV   = 2,
  parameter int DEFAULT_HIGH  = 1,
  parameter int DEFAULT_PHASE = 0
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [4:0]            cfg_chan,
  input  logic [CNT_W-1:0]      cfg_div,
  input  logic [CNT_W-1:0]      cfg_high,
  input  logic [CNT_W-1:0]      cfg_phase,
  output logic                  cfg_err,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_rise,
  output logic                  locked
);
  localparam int SW = LOCK_CYCLES > 1 ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [SW-1:0] LAST = SW'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  typedef enum logic [1:0] {S_RESET, S_SETTLE, S_LOCKED} state_t;
  state_t state, state_n;
  logic [SW-1:0] settle_cnt;
  logic accept, chan_ok, cfg_hit, restart;
  assign cfg_ready = state != S_RESET;
  assign locked    = state == S_LOCKED;
  assign accept    = cfg_valid && cfg_ready;
  assign chan_ok   = cfg_chan < 5'(NUM_CLOCKS);
  assign cfg_hit   = accept && chan_ok;
  // leaving reset and every accepted channel update realign all channels
  assign restart   = state == S_RESET || cfg_hit;
  // state register
  always_ff @(posedge refclk) state <= !rst ? S_RESET : state_n;
  // next state: restart wins, otherwise settle until the lock count expires
  always_comb begin
    state_n = restart ? S_SETTLE : (state == S_SETTLE && settle_cnt == LAST) ? S_LOCKED : state;
  end
  // settle counter tracks k during SETTLE; cfg_err flags a request to a missing channel
  always_ff @(posedge refclk) begin
    if (!rst) begin
      settle_cnt <= '0;
      cfg_err    <= 1'b0;
    end else begin
      settle_cnt <= restart ? '0 : state == S_SETTLE ? settle_cnt + SW'(1) : settle_cnt;
      cfg_err    <= accept && !chan_ok;
    end
  end
  for (genvar c = 0; c < NUM_CLOCKS; c++) begin : g_ch
    logic [CNT_W-1:0] div_r, high_r, phase_r, div_e, high_e, phase_e;
    logic [CNT_W-1:0] rem, per, rem_n, per_n;
    logic sel, out_n, out_q, rise_q;
    assign sel     = cfg_hit && cfg_chan == 5'(c);
    assign div_e   = sel ? cfg_div : div_r;
    assign high_e  = sel ? cfg_high : high_r;
    assign phase_e = sel ? cfg_phase : phase_r;
    // rem counts down the phase delay; per is the position within the period once running
    always_comb begin
      rem_n = restart ? phase_e : rem != '0 ? rem - ONE : '0;
      per_n = (restart || rem != '0 || per == div_e - ONE) ? '0 : per + ONE;
      out_n = div_e != '0 && rem_n == '0 && per_n < high_e;
    end
    // shadow settings, counters and registered waveform outputs
    always_ff @(posedge refclk) begin
      if (!rst) begin
        div_r   <= CNT_W'(DEFAULT_DIV);
        high_r  <= CNT_W'(DEFAULT_HIGH);
        phase_r <= CNT_W'(DEFAULT_PHASE);
        rem     <= '0;
        per     <= '0;
        out_q   <= 1'b0;
        rise_q  <= 1'b0;
      end else begin
        if (sel) begin
          div_r   <= cfg_div;
          high_r  <= cfg_high;
          phase_r <= cfg_phase;
        end
        rem    <= rem_n;
        per    <= per_n;
        out_q  <= out_n;
        rise_q <= out_n && !out_q;
      end
    end
    assign outclk[c]      = out_q;
    assign outclk_rise[c] = rise_q;
  end
endmodule

// File: tb/tb_multi_clkgen.sv
// tb_multi_clkgen: scoreboard bench comparing multi_clkgen against a closed-form waveform model
module tb_multi_clkgen;
  localparam int N = 4;
  localparam int W = 16;
  localparam int LC = 16;
  logic refclk = 1'b0;
  logic rst = 1'b0;
  logic cfg_valid = 1'b0;
  logic cfg_ready, cfg_err, locked;
  logic [4:0] cfg_chan = '0;
  logic [W-1:0] cfg_div = '0, cfg_high = '0, cfg_phase = '0;
  logic [N-1:0] outclk, outclk_rise;
  multi_clkgen #(.NUM_CLOCKS(N), .CNT_W(W), .LOCK_CYCLES(LC), .DEFAULT_DIV(2), .DEFAULT_HIGH(1), .DEFAULT_PHASE(0)) dut (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
    .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_phase(cfg_phase), .cfg_err(cfg_err),
    .outclk(outclk), .outclk_rise(outclk_rise), .locked(locked)
  );
  always #5 refclk = ~refclk;
  int m_div[N], m_high[N], m_phase[N];
  int k = 0;
  bit running = 1'b0;
  logic [N-1:0] m_prev = '0;
  logic [2*N+2:0] exp_q[$];
  logic [2*N+2:0] got, exp_v;
  int total = 0, passed = 0, cyc = 0;
  function automatic logic [N-1:0] wave(int kk);
    logic [N-1:0] w;
    w = '0;
    for (int c = 0; c < N; c++)
      if (m_div[c] != 0 && kk >= m_phase[c])
        w[c] = ((kk - m_phase[c]) % m_div[c]) < m_high[c];
    return w;
  endfunction
  task automatic step();
    logic err;
    logic [N-1:0] o, r;
    err = 1'b0;
    if (!rst) begin
      running = 1'b0;
      for (int c = 0; c < N; c++) begin
        m_div[c] = 2; m_high[c] = 1; m_phase[c] = 0;
      end
    end else if (!running) begin
      running = 1'b1; k = 0;
    end else if (cfg_valid && cfg_chan < N) begin
      m_div[cfg_chan] = int'(cfg_div); m_high[cfg_chan] = int'(cfg_high); m_phase[cfg_chan] = int'(cfg_phase);
      k = 0;
    end else begin
      err = cfg_valid; k++;
    end
    o = running ? wave(k) : '0;
    r = o & ~m_prev;
    m_prev = o;
    exp_q.push_back({o, r, running && k >= LC, running, err});
    @(posedge refclk); #1; cyc++;
  endtask
  task automatic req(input logic v, input int ch, input int d, input int h, input int p);
    cfg_valid = v; cfg_chan = 5'(ch); cfg_div = W'(d); cfg_high = W'(h); cfg_phase = W'(p);
  endtask
  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 23; i++) begin
      if (i == 3) rst = 1'b1;
      step();
      got = {outclk, outclk_rise, locked, cfg_ready, cfg_err}; exp_v = exp_q.pop_front(); total++;
      if (got !== exp_v) $display("FAIL reset cyc=%0d got %b required %b", cyc, got, exp_v);
      else passed++;
    end
  endtask
  task automatic test_program();
    for (int i = 0; i < 22; i++) begin
      if (i == 0) req(1, 1, 5, 2, 3); else req(0, 0, 0, 0, 0);
      step();
      got = {outclk, outclk_rise, locked, cfg_ready, cfg_err}; exp_v = exp_q.pop_front(); total++;
      if (got !== exp_v) $display("FAIL program cyc=%0d got %b required %b", cyc, got, exp_v);
      else passed++;
    end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      if (i == 0) req(1, 2, 2, 0, 0);
      else if (i == 1) req(1, 3, 4, 7, 0);
      else if (i == 2) req(1, 0, 0, 1, 0);
      else req(0, 0, 0, 0, 0);
      step();
      got = {outclk, outclk_rise, locked, cfg_ready, cfg_err}; exp_v = exp_q.pop_front(); total++;
      if (got !== exp_v) $display("FAIL duty cyc=%0d got %b required %b", cyc, got, exp_v);
      else passed++;
    end
  endtask
  task automatic test_invalid();
    for (int i = 0; i < 6; i++) begin
      if (i == 0) req(1, 9, 3, 1, 1); else req(0, 0, 0, 0, 0);
      step();
      got = {outclk, outclk_rise, locked, cfg_ready, cfg_err}; exp_v = exp_q.pop_front(); total++;
      if (got !== exp_v) $display("FAIL invalid cyc=%0d got %b required %b", cyc, got, exp_v);
      else passed++;
    end
  endtask
  task automatic test_midsettle();
    for (int i = 0; i < 34; i++) begin
      if (i == 0) req(1, 1, 3, 1, 2);
      else if (i == 11) req(1, 2, 3, 2, 1);
      else if (i == 13) req(1, 3, 6, 3, 4);
      else req(0, 0, 0, 0, 0);
      step();
      got = {outclk, outclk_rise, locked, cfg_ready, cfg_err}; exp_v = exp_q.pop_front(); total++;
      if (got !== exp_v) $display("FAIL midsettle cyc=%0d got %b required %b", cyc, got, exp_v);
      else passed++;
    end
  endtask
  task automatic test_reset_mid();
    for (int i = 0; i < 22; i++) begin
      rst = i != 0;
      req(i == 0, 1, 7, 3, 0);
      step();
      got = {outclk, outclk_rise, locked, cfg_ready, cfg_err}; exp_v = exp_q.pop_front(); total++;
      if (got !== exp_v) $display("FAIL reset_mid cyc=%0d got %b required %b", cyc, got, exp_v);
      else passed++;
      cfg_valid = 1'b0;
    end
  endtask
  initial begin
    #1;
    test_reset();
    test_program();
    test_back_to_back();
    test_invalid();
    test_midsettle();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
